ps2_keypad_decoder: RTL and testbench

//  Parametrised PS/2 keyboard receiver and key-state tracker in the clk domain. It oversamples
//  ps2_clk/ps2_data, frames 11-bit packets, checks start/parity/stop and decodes F0/E0 prefixes.
//  It maintains a held/pressed vector for a table of NUM_KEYS scan codes, which feeds game control.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_frame_rx.sv | 135 +++++++++++++
 rtl/ps2_keypad_decoder.sv | 122 ++++++++++++
 tb/tb_ps2_keypad_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and parity helper for the PS/2 keypad decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Parity bit that makes {b, parity} contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronises ps2_clk/ps2_data, detects clock falls and frames
// 11-bit packets with start/parity/stop checking and an inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   prev_q, prev_d;
    logic                   fall_q, fall_d;
    logic                   samp_q, samp_d;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    // Next-state logic: synchroniser, fall detect, frame FSM and timeout counter.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        prev_d      = clk_sync_q[SYNC_STAGES-1];
        fall_d      = prev_q & ~clk_sync_q[SYNC_STAGES-1];
        samp_d      = data_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (fall_q) begin
                if (!samp_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (fall_q) begin
            cnt_d = '0;
            case (state_q)
                DATA: begin
                    shift_d   = {samp_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    par_d   = samp_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (samp_q && (par_q == odd_parity(shift_q))) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Clock stalled mid-frame: abandon the partial byte.
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers; lines idle high so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_q      <= 1'b1;
            fall_q      <= 1'b0;
            samp_q      <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            prev_q      <= prev_d;
            fall_q      <= fall_d;
            samp_q      <= samp_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign rx_byte   = byte_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard receiver with break/extended prefix decode and a held/pressed key table.
// Define PS2_EXT_EN to make E0-prefixed keys distinct from their plain counterparts.
module ps2_keypad_decoder
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS       = 5,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = 40'h72_75_74_5A_6B,
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = 5'b11101,
    parameter int                      SYNC_STAGES    = 2,
    parameter int                      TIMEOUT_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          rx_byte,
    output logic                rx_valid,
    output logic                frame_err
);

    logic [7:0]          byte_s;
    logic                valid_s;
    logic                err_s;
    logic [NUM_KEYS-1:0] match_s;
    logic [NUM_KEYS-1:0] ext_ok_s;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
`ifdef PS2_EXT_EN
    logic                ext_q, ext_d;
`endif

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (byte_s),
        .rx_valid  (valid_s),
        .frame_err (err_s)
    );

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
`ifdef PS2_EXT_EN
        assign ext_ok_s[i] = (ext_q == KEY_EXT[i]);
`else
        // Extended flag is not tracked: every key accepts either prefix state.
        assign ext_ok_s[i] = KEY_EXT[i] | 1'b1;
`endif
        assign match_s[i] = (byte_s == KEY_CODES[8*i +: 8]) && ext_ok_s[i];
    end

    // Prefix flags and key table update on each received byte.
    always_comb begin
        brk_d   = brk_q;
        held_d  = held_q;
        press_d = '0;
`ifdef PS2_EXT_EN
        ext_d   = ext_q;
`endif
        if (err_s) begin
            brk_d = 1'b0;
`ifdef PS2_EXT_EN
            ext_d = 1'b0;
`endif
        end else if (valid_s) begin
            if (byte_s == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (byte_s == PS2_EXT) begin
`ifdef PS2_EXT_EN
                ext_d = 1'b1;
`else
                brk_d = brk_q;
`endif
            end else begin
                if (brk_q) begin
                    held_d = held_q & ~match_s;
                end else begin
                    held_d  = held_q | match_s;
                    press_d = match_s & ~held_q;
                end
                brk_d = 1'b0;
`ifdef PS2_EXT_EN
                ext_d = 1'b0;
`endif
            end
        end else begin
            brk_d = brk_q;
        end
    end

    // Registered flags and key outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_q   <= 1'b0;
            held_q  <= '0;
            press_q <= '0;
`ifdef PS2_EXT_EN
            ext_q   <= 1'b0;
`endif
        end else begin
            brk_q   <= brk_d;
            held_q  <= held_d;
            press_q <= press_d;
`ifdef PS2_EXT_EN
            ext_q   <= ext_d;
`endif
        end
    end

    assign key_held  = held_q;
    assign key_press = press_q;
    assign rx_byte   = byte_s;
    assign rx_valid  = valid_s;
    assign frame_err = err_s;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Directed bench for ps2_keypad_decoder: frames PS/2 bytes bit by bit and checks key state.
module tb_ps2_keypad_decoder;

    localparam int T    = 10000;
    localparam int SYNC = 2;
    localparam int H    = 8;
    localparam logic [4:0] KEXT = 5'b11101;
`ifdef PS2_EXT_EN
    localparam bit EXT_ON = 1'b1;
`else
    localparam bit EXT_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] key_held;
    logic [4:0] key_press;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int err_cyc  = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int both     = 0;
    int press_cnt [5];
    int v0, e0, p0;

    ps2_keypad_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_held  (key_held),
        .key_press (key_press),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) n_valid <= n_valid + 1;
        if (frame_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (rx_valid && frame_err) both <= both + 1;
        for (int i = 0; i < 5; i++) begin
            if (key_press[i]) press_cnt[i] <= press_cnt[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ps2_pulse(input logic d);
        ps2_data = d;
        repeat (H) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (H) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_pulse(fr[i]);
        ps2_data = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] code, input logic ext, input logic brk);
        if (EXT_ON && ext) send_frame(8'hE0, 1'b0, 11);
        if (brk) send_frame(8'hF0, 1'b0, 11);
        send_frame(code, 1'b0, 11);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) press_cnt[i] = 0;
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_held", 32'(key_held), 32'h0);
        check_eq("rst_press", 32'(key_press), 32'h0);
        check_eq("rst_byte", 32'(rx_byte), 32'h0);
        check_eq("rst_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_err", 32'(frame_err), 32'h0);

        // 1: first make of key 0
        v0 = n_valid;
        send_key(8'h6B, KEXT[0], 1'b0);
        check_eq("t1_byte", 32'(rx_byte), 32'h6B);
        check_eq("t1_valid_cnt", 32'(n_valid - v0), 32'(EXT_ON ? 2 : 1));
        check_eq("t1_held", 32'(key_held), 32'h01);
        check_eq("t1_press", 32'(press_cnt[0]), 32'd1);

        // 2: typematic repeats, then break
        repeat (3) send_key(8'h6B, KEXT[0], 1'b0);
        check_eq("t2_press_rep", 32'(press_cnt[0]), 32'd1);
        check_eq("t2_held_rep", 32'(key_held), 32'h01);
        if (EXT_ON) send_frame(8'hE0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        check_eq("t2_held_after_f0", 32'(key_held), 32'h01);
        send_frame(8'h6B, 1'b0, 11);
        check_eq("t2_held_break", 32'(key_held), 32'h00);
        check_eq("t2_press_final", 32'(press_cnt[0]), 32'd1);
        check_eq("t2_no_err", 32'(n_err), 32'd0);

        // 3: parity error on 5A
        v0 = n_valid; e0 = n_err;
        send_frame(8'h5A, 1'b1, 11);
        check_eq("t3_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
        check_eq("t3_held", 32'(key_held), 32'h00);
        check_eq("t3_byte_kept", 32'(rx_byte), 32'h6B);

        // Bad start bit in idle
        e0 = n_err;
        ps2_pulse(1'b1);
        repeat (2*H) @(negedge clk);
        check_eq("bad_start_err", 32'(n_err - e0), 32'd1);

        // 4: stall after start + 4 data bits; raw fall -> sync -> registered fall
        // reloads the counter SYNC+2 cycles later, error T cycles after that.
        e0 = n_err;
        send_frame(8'h74, 1'b0, 5);
        for (int k = 0; k < T + 100; k++) begin
            if (n_err != e0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_eq("t4_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("t4_err_time", 32'(err_cyc - fall_cyc), 32'(T + SYNC + 2));
        send_key(8'h74, KEXT[2], 1'b0);
        check_eq("t4_held", 32'(key_held), 32'h04);

        // 5: plain 75 matches only when the extended flag is not tracked
        send_frame(8'h75, 1'b0, 11);
        check_eq("t5_plain75", 32'(key_held), EXT_ON ? 32'h04 : 32'h0C);
        send_key(8'h75, KEXT[3], 1'b0);
        check_eq("t5_ext75", 32'(key_held), 32'h0C);
        send_key(8'h75, KEXT[3], 1'b1);
        check_eq("t5_rel75", 32'(key_held), 32'h04);
        send_key(8'h6B, KEXT[0], 1'b0);
        check_eq("t5_held_00101", 32'(key_held), 32'h05);
        check_eq("t5_repress0", 32'(press_cnt[0]), 32'd2);

        // 6: reset mid-frame
        send_frame(8'h72, 1'b0, 4);
        reset = 1'b0;
        #1;
        check_eq("t6_held0", 32'(key_held), 32'h0);
        check_eq("t6_byte0", 32'(rx_byte), 32'h0);
        check_eq("t6_flags0", 32'({rx_valid, frame_err, key_press}), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        p0 = press_cnt[4]; e0 = n_err;
        send_key(8'h72, KEXT[4], 1'b0);
        check_eq("t6_held", 32'(key_held), 32'h10);
        check_eq("t6_press4", 32'(press_cnt[4] - p0), 32'd1);
        check_eq("t6_byte", 32'(rx_byte), 32'h72);
        check_eq("t6_no_err", 32'(n_err - e0), 32'd0);
        check_eq("never_both", 32'(both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
